// File: rtl/reg_bank_shift.sv
// reg_bank_shift: CH-channel, N-bit register bank with masked parallel load,
// serial shift (channel 0 in, channel CH-1 out), synchronous clear, per-channel
// valid tracking and a registered shift-out word.
module reg_bank_shift #(
    parameter  int N  = 5,
    parameter  int CH = 4,
    localparam int CW = $clog2(CH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [CH-1:0]   ld_mask,
    input  logic [CH*N-1:0] in_bus,
    input  logic [N-1:0]    ser_in,
    output logic [CH*N-1:0] out_bus,
    output logic [CH-1:0]   valid,
    output logic [CW-1:0]   fill_cnt,
    output logic            full,
    output logic [N-1:0]    sh_out,
    output logic            sh_out_vld
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    logic [CH-1:0][N-1:0] r_ch;
    logic [CH-1:0]        r_valid;
    logic [N-1:0]         r_sh_out;
    logic                 r_sh_vld;
    mode_e                w_mode;
    logic [CW-1:0]        w_cnt;

    assign w_mode = mode_e'(mode);

    // Channel, valid and shift-out registers; en gates every update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch     <= '0;
            r_valid  <= '0;
            r_sh_out <= '0;
            r_sh_vld <= 1'b0;
        end else if (en) begin
            case (w_mode)
                MODE_HOLD: begin
                    r_sh_vld <= 1'b0;
                end
                MODE_LOAD: begin
                    for (int unsigned k = 0; k < CH; k++) begin
                        if (ld_mask[k]) begin
                            r_ch[k]    <= in_bus[k*N +: N];
                            r_valid[k] <= 1'b1;
                        end
                    end
                    r_sh_vld <= 1'b0;
                end
                MODE_SHIFT: begin
                    r_sh_out <= r_ch[CH-1];
                    r_sh_vld <= r_valid[CH-1];
                    r_ch     <= {r_ch[CH-2:0], ser_in};
                    r_valid  <= {r_valid[CH-2:0], 1'b1};
                end
                MODE_CLEAR: begin
                    r_ch     <= '0;
                    r_valid  <= '0;
                    r_sh_out <= '0;
                    r_sh_vld <= 1'b0;
                end
                default: begin
                    r_sh_vld <= r_sh_vld;
                end
            endcase
        end
    end

    // Fill count is a popcount of the valid register, so it cannot drift.
    always_comb begin
        w_cnt = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            w_cnt = w_cnt + CW'(r_valid[k]);
        end
    end

    assign out_bus    = r_ch;
    assign valid      = r_valid;
    assign fill_cnt   = w_cnt;
    assign full       = (w_cnt == CW'(CH));
    assign sh_out     = r_sh_out;
    assign sh_out_vld = r_sh_vld;

endmodule

// File: tb/tb_reg_bank_shift.sv
// Directed self-checking bench for reg_bank_shift (CH=4/N=5 and CH=8/N=16).
module tb_reg_bank_shift;

    logic        clk;
    logic        rst;

    // CH=4, N=5 instance signals
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  ld_mask;
    logic [19:0] in_bus;
    logic [4:0]  ser_in;
    logic [19:0] out_bus;
    logic [3:0]  valid;
    logic [2:0]  fill_cnt;
    logic        full;
    logic [4:0]  sh_out;
    logic        sh_out_vld;

    // CH=8, N=16 instance signals
    logic         en8;
    logic [1:0]   mode8;
    logic [7:0]   ld_mask8;
    logic [127:0] in_bus8;
    logic [15:0]  ser_in8;
    logic [127:0] out_bus8;
    logic [7:0]   valid8;
    logic [3:0]   fill_cnt8;
    logic         full8;
    logic [15:0]  sh_out8;
    logic         sh_out_vld8;

    int checks = 0;
    int errors = 0;

    reg_bank_shift #(.N(5), .CH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .ld_mask(ld_mask),
        .in_bus(in_bus), .ser_in(ser_in), .out_bus(out_bus), .valid(valid),
        .fill_cnt(fill_cnt), .full(full), .sh_out(sh_out), .sh_out_vld(sh_out_vld)
    );

    reg_bank_shift #(.N(16), .CH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .mode(mode8), .ld_mask(ld_mask8),
        .in_bus(in_bus8), .ser_in(ser_in8), .out_bus(out_bus8), .valid(valid8),
        .fill_cnt(fill_cnt8), .full(full8), .sh_out(sh_out8), .sh_out_vld(sh_out_vld8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (out_bus !== 20'd0) begin errors++; $display("FAIL reset_out_bus got %h exp %h", out_bus, 20'd0); end
        checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp %b", valid, 4'b0000); end
        checks++; if (fill_cnt !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (sh_out !== 5'd0 || sh_out_vld !== 1'b0) begin errors++; $display("FAIL reset_sh got %h/%b exp 00/0", sh_out, sh_out_vld); end
        checks++; if (out_bus8 !== 128'd0 || fill_cnt8 !== 4'd0) begin errors++; $display("FAIL reset_ch8 got %h/%0d exp 0/0", out_bus8, fill_cnt8); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; mode = 2'b01; ld_mask = 4'b1111; in_bus = {4{5'h1F}};
        step();
        checks++; if (out_bus !== {4{5'h1F}} || fill_cnt !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL load_all got %h/%0d/%b exp %h/4/1", out_bus, fill_cnt, full, {4{5'h1F}}); end
        mode = 2'b10; ser_in = 5'h1F;
        step();
        checks++; if (sh_out !== 5'h1F || sh_out_vld !== 1'b1) begin errors++; $display("FAIL pre_reset_shift got %h/%b exp 1f/1", sh_out, sh_out_vld); end
        #3 rst = 1'b0;
        #1;
        checks++; if (out_bus !== 20'd0 || valid !== 4'b0000) begin errors++; $display("FAIL async_reset_data got %h/%b exp 0/0000", out_bus, valid); end
        checks++; if (fill_cnt !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL async_reset_fill got %0d/%b exp 0/0", fill_cnt, full); end
        checks++; if (sh_out !== 5'd0 || sh_out_vld !== 1'b0) begin errors++; $display("FAIL async_reset_sh got %h/%b exp 00/0", sh_out, sh_out_vld); end
        #1 rst = 1'b1;
        mode = 2'b00;
    endtask

    task automatic test_masked_load();
        en = 1'b1; mode = 2'b01; ld_mask = 4'b0101; in_bus = {5'd4, 5'd3, 5'd2, 5'd1};
        step();
        checks++; if (out_bus !== {5'd0, 5'd3, 5'd0, 5'd1}) begin errors++; $display("FAIL masked_load_data got %h exp %h", out_bus, {5'd0, 5'd3, 5'd0, 5'd1}); end
        checks++; if (valid !== 4'b0101 || fill_cnt !== 3'd2 || full !== 1'b0) begin errors++; $display("FAIL masked_load_valid got %b/%0d/%b exp 0101/2/0", valid, fill_cnt, full); end
        // Shifting out an invalid slot: ch3 is not valid
        mode = 2'b10; ser_in = 5'd6;
        step();
        checks++; if (sh_out_vld !== 1'b0 || sh_out !== 5'd0) begin errors++; $display("FAIL shift_invalid_slot got %h/%b exp 00/0", sh_out, sh_out_vld); end
        checks++; if (out_bus !== {5'd3, 5'd0, 5'd1, 5'd6} || valid !== 4'b1011 || fill_cnt !== 3'd3) begin errors++; $display("FAIL shift_partial got %h/%b/%0d exp %h/1011/3", out_bus, valid, fill_cnt, {5'd3, 5'd0, 5'd1, 5'd6}); end
    endtask

    task automatic test_clear();
        en = 1'b1; mode = 2'b11;
        step();
        checks++; if (out_bus !== 20'd0 || valid !== 4'b0000 || fill_cnt !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL sync_clear got %h/%b/%0d/%b exp 0/0000/0/0", out_bus, valid, fill_cnt, full); end
        checks++; if (sh_out !== 5'd0 || sh_out_vld !== 1'b0) begin errors++; $display("FAIL sync_clear_sh got %h/%b exp 00/0", sh_out, sh_out_vld); end
    endtask

    task automatic test_shift_fill();
        logic [4:0] vals [4] = '{5'd7, 5'd8, 5'd9, 5'd10};
        en = 1'b1; mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            ser_in = vals[i];
            step();
            checks++; if (fill_cnt !== 3'(i + 1)) begin errors++; $display("FAIL fill_cnt_%0d got %0d exp %0d", i, fill_cnt, i + 1); end
            checks++; if (full !== (i == 3) || sh_out_vld !== 1'b0) begin errors++; $display("FAIL fill_flags_%0d got full=%b vld=%b exp full=%b vld=0", i, full, sh_out_vld, (i == 3)); end
        end
        checks++; if (out_bus !== {5'd7, 5'd8, 5'd9, 5'd10}) begin errors++; $display("FAIL fill_data got %h exp %h", out_bus, {5'd7, 5'd8, 5'd9, 5'd10}); end
    endtask

    task automatic test_shift_full();
        en = 1'b1; mode = 2'b10; ser_in = 5'd11;
        step();
        checks++; if (sh_out !== 5'd7 || sh_out_vld !== 1'b1) begin errors++; $display("FAIL shift_full_out got %h/%b exp 07/1", sh_out, sh_out_vld); end
        checks++; if (out_bus !== {5'd8, 5'd9, 5'd10, 5'd11} || fill_cnt !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL shift_full_data got %h/%0d/%b exp %h/4/1", out_bus, fill_cnt, full, {5'd8, 5'd9, 5'd10, 5'd11}); end
        mode = 2'b00;
        step();
        checks++; if (sh_out !== 5'd7 || sh_out_vld !== 1'b0) begin errors++; $display("FAIL hold_after_shift got %h/%b exp 07/0", sh_out, sh_out_vld); end
        checks++; if (out_bus !== {5'd8, 5'd9, 5'd10, 5'd11}) begin errors++; $display("FAIL hold_data got %h exp %h", out_bus, {5'd8, 5'd9, 5'd10, 5'd11}); end
    endtask

    task automatic test_enable_gating();
        en = 1'b1; mode = 2'b10; ser_in = 5'd12;
        step();
        checks++; if (sh_out !== 5'd8 || sh_out_vld !== 1'b1) begin errors++; $display("FAIL gate_setup got %h/%b exp 08/1", sh_out, sh_out_vld); end
        en = 1'b0; ser_in = 5'd20; ld_mask = 4'b1111; in_bus = {4{5'h15}};
        for (int i = 0; i < 6; i++) begin
            mode = (i < 3) ? 2'b10 : 2'b11;
            step();
            checks++; if (out_bus !== {5'd9, 5'd10, 5'd11, 5'd12} || valid !== 4'b1111) begin errors++; $display("FAIL gate_data_%0d got %h/%b exp %h/1111", i, out_bus, valid, {5'd9, 5'd10, 5'd11, 5'd12}); end
            checks++; if (sh_out !== 5'd8 || sh_out_vld !== 1'b1) begin errors++; $display("FAIL gate_sh_%0d got %h/%b exp 08/1", i, sh_out, sh_out_vld); end
        end
        // Zero-mask load: data holds but sh_out_vld still clears
        en = 1'b1; mode = 2'b01; ld_mask = 4'b0000;
        step();
        checks++; if (out_bus !== {5'd9, 5'd10, 5'd11, 5'd12} || sh_out_vld !== 1'b0 || sh_out !== 5'd8) begin errors++; $display("FAIL zero_mask_load got %h/%h/%b exp %h/08/0", out_bus, sh_out, sh_out_vld, {5'd9, 5'd10, 5'd11, 5'd12}); end
    endtask

    task automatic test_ch8();
        logic [127:0] exp8;
        en8 = 1'b1; mode8 = 2'b10;
        for (int i = 0; i < 8; i++) begin
            ser_in8 = 16'h1000 + 16'(i);
            step();
            checks++; if (fill_cnt8 !== 4'(i + 1) || full8 !== (i == 7)) begin errors++; $display("FAIL ch8_fill_%0d got %0d/%b exp %0d/%b", i, fill_cnt8, full8, i + 1, (i == 7)); end
        end
        for (int k = 0; k < 8; k++) exp8[k*16 +: 16] = 16'h1000 + 16'(7 - k);
        checks++; if (out_bus8 !== exp8 || valid8 !== 8'hFF) begin errors++; $display("FAIL ch8_data got %h/%h exp %h/ff", out_bus8, valid8, exp8); end
        ser_in8 = 16'hBEEF;
        step();
        checks++; if (sh_out8 !== 16'h1000 || sh_out_vld8 !== 1'b1 || fill_cnt8 !== 4'd8) begin errors++; $display("FAIL ch8_shift_full got %h/%b/%0d exp 1000/1/8", sh_out8, sh_out_vld8, fill_cnt8); end
        mode8 = 2'b11;
        step();
        checks++; if (out_bus8 !== 128'd0 || fill_cnt8 !== 4'd0 || full8 !== 1'b0 || sh_out_vld8 !== 1'b0) begin errors++; $display("FAIL ch8_clear got %h/%0d/%b/%b exp 0/0/0/0", out_bus8, fill_cnt8, full8, sh_out_vld8); end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0; mode = 2'b00; ld_mask = '0; in_bus = '0; ser_in = '0;
        en8 = 1'b0; mode8 = 2'b00; ld_mask8 = '0; in_bus8 = '0; ser_in8 = '0;
        #12;
        test_reset();
        rst = 1'b1;
        test_reset_mid();
        test_masked_load();
        test_clear();
        test_shift_fill();
        test_shift_full();
        test_enable_gating();
        test_clear();
        test_ch8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
